// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: iterative RV32M multiply/divide unit that sits beside the ALU.
//   Radix-2 shift-add multiply and restoring divide, one bit per clock.
//   Only one operation is in flight at a time. The result appears WIDTH+1
//   cycles after accept. Divide-by-zero and signed MIN_INT/-1 take a 1-cycle
//   bypass.
//
// Build option: define MDU_FLAGS_EN to register the Zero/Overflow flags with D.
//   When it is undefined, both flags are tied to 0.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operands/op valid       in_ready   unit idle, can accept
//   A, B       operands                MDsel      RV32M op select (funct3)
//   kill       abort any in-flight op, discard result
//   out_valid  D valid                 out_ready  consumer takes D
//   D          result                  Zero/Overflow  optional flags
//
// state | meaning
// IDLE  | waiting for an op, in_ready=1
// CALC  | WIDTH iterations of shift-add / restoring divide
// FIX   | sign correction and high/low select (or special-case result)
// DONE  | D valid, held until out_ready

module alu_muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       MDsel,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Zero,
  output logic             Overflow
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  localparam logic [WIDTH-1:0] MIN_INT  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             neg_q, neg_d;
  logic             spec_q, spec_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] d_q, d_d;

  logic             accept;
  logic             signed_a, signed_b;
  logic             neg_in;
  logic             div_zero, div_ovf;
  logic [WIDTH-1:0] a_mag, b_mag, spec_res;
  logic [WIDTH:0]   mul_sum, rem_sh, rem_diff;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0] quo_s, rem_s, res;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign D         = d_q;
  // kill has priority over a same-cycle accept
  assign accept    = in_valid & in_ready & ~kill;

  // Operand decode at accept time. The core always works on magnitudes,
  // so the sign of the result is resolved here and corrected in FIX.
  always_comb begin
    signed_a = (MDsel == OP_MUL) || (MDsel == OP_MULH) || (MDsel == OP_MULHSU) ||
               (MDsel == OP_DIV) || (MDsel == OP_REM);
    signed_b = (MDsel == OP_MUL) || (MDsel == OP_MULH) ||
               (MDsel == OP_DIV) || (MDsel == OP_REM);
    a_mag    = (signed_a && A[WIDTH-1]) ? -A : A;
    b_mag    = (signed_b && B[WIDTH-1]) ? -B : B;
    neg_in   = 1'b0;
    if (MDsel[2]) begin
      // quotient sign is the xor of the operand signs; remainder follows the dividend
      if (MDsel == OP_DIV)      neg_in = A[WIDTH-1] ^ B[WIDTH-1];
      else if (MDsel == OP_REM) neg_in = A[WIDTH-1];
    end else begin
      neg_in = (signed_a & A[WIDTH-1]) ^ (signed_b & B[WIDTH-1]);
    end
    div_zero = MDsel[2] && (B == '0);
    div_ovf  = MDsel[2] && signed_a && (A == MIN_INT) && (B == '1);
    // MDsel[1] separates REM/REMU from DIV/DIVU
    if (div_zero) spec_res = MDsel[1] ? A : '1;
    else          spec_res = MDsel[1] ? '0 : MIN_INT;
  end

  // Iteration datapath and final correction
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh   = {hi_q, lo_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, opnd_q};
    prod_s   = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    quo_s    = neg_q ? -lo_q : lo_q;
    rem_s    = neg_q ? -hi_q : hi_q;
    if (spec_q)        res = lo_q;
    else if (op_q[2])  res = op_q[1] ? rem_s : quo_s;
    else if (op_q == OP_MUL) res = prod_s[WIDTH-1:0];
    else               res = prod_s[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    spec_d  = spec_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    d_d     = d_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d  = MDsel;
          neg_d = neg_in;
          hi_d  = '0;
          if (div_zero || div_ovf) begin
            // bypass: result parked in lo and released through FIX
            spec_d  = 1'b1;
            lo_d    = spec_res;
            opnd_d  = '0;
            cnt_d   = '0;
            state_d = ST_FIX;
          end else begin
            spec_d  = 1'b0;
            cnt_d   = CNT_LOAD;
            state_d = ST_CALC;
            if (MDsel[2]) begin
              lo_d   = a_mag;
              opnd_d = b_mag;
            end else begin
              lo_d   = b_mag;
              opnd_d = a_mag;
            end
          end
        end
      end
      ST_CALC: begin
        cnt_d = cnt_q - CNT_ONE;
        if (op_q[2]) begin
          // restoring divide: dividend shifts out of lo MSB, quotient bits enter at LSB
          hi_d = rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], ~rem_diff[WIDTH]};
        end else begin
          // shift-add: {hi,lo} shifts right, multiplier bits leave from lo LSB
          hi_d = mul_sum[WIDTH:1];
          lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_ONE) state_d = ST_FIX;
      end
      ST_FIX: begin
        d_d     = res;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (kill) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      d_d     = d_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      spec_q  <= 1'b0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      spec_q  <= spec_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      d_q     <= d_d;
    end
  end

`ifdef MDU_FLAGS_EN
  logic zero_q, ovf_q, spec_ovf_q;
  logic mul_ovf;

  // MUL overflows when the signed high half is not the sign extension of the low half
  assign mul_ovf = (op_q == OP_MUL) &&
                   (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
      spec_ovf_q <= 1'b0;
    end else begin
      if (accept) spec_ovf_q <= div_ovf;
      if ((state_q == ST_FIX) && !kill) begin
        zero_q <= (res == '0);
        ovf_q  <= spec_q ? spec_ovf_q : mul_ovf;
      end
    end
  end

  assign Zero     = zero_q;
  assign Overflow = ovf_q;
`else
  assign Zero     = 1'b0;
  assign Overflow = 1'b0;
`endif

endmodule
